// File: rtl/mem_access_ctrl.sv
// Sequencer that turns one byte/word read or write request into the MAR/MDR
// strobe sequence of the SAP-2 memory block. Words are little-endian.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        word,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] mem_data,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  output logic        mar_load,
  output logic        mdr_load_bus,
  output logic        mdr_load_low,
  output logic        mdr_load_high,
  output logic        ram_write,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, R_ALO, R_LO, R_AHI, R_HI, R_CAP,
    W_ALO, W_DLO, W_WLO, W_AHI, W_DHI, W_WHI
  } state_t;

  typedef struct packed {
    logic        we;
    logic        word;
    logic [15:0] addr;
    logic [15:0] hi_addr;
    logic [15:0] wdata;
  } req_t;

  state_t state, nxt;
  req_t   lat;
  logic   done_nxt;
  logic [15:0] hi_addr;

  // 16-bit add wraps 16'hFFFF to 16'h0000 for the high byte of a word
  assign hi_addr = addr + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lat   <= '0;
      rdata <= '0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      done  <= done_nxt;
      if (state == IDLE && req)
        lat <= '{we: we, word: word, addr: addr, hi_addr: hi_addr, wdata: wdata};
      if (state == R_CAP)
        rdata <= lat.word ? mem_data : {8'h00, mem_data[7:0]};
    end
  end

  always_comb begin
    nxt           = state;
    done_nxt      = 1'b0;
    bus_out       = '0;
    bus_oe        = 1'b0;
    mar_load      = 1'b0;
    mdr_load_bus  = 1'b0;
    mdr_load_low  = 1'b0;
    mdr_load_high = 1'b0;
    ram_write     = 1'b0;
    case (state)
      IDLE: if (req) nxt = we ? W_ALO : R_ALO;
      R_ALO: begin
        bus_out = lat.addr; bus_oe = 1'b1; mar_load = 1'b1;
        nxt = R_LO;
      end
      R_LO: begin
        mdr_load_low = 1'b1;
        nxt = lat.word ? R_AHI : R_CAP;
      end
      R_AHI: begin
        bus_out = lat.hi_addr; bus_oe = 1'b1; mar_load = 1'b1;
        nxt = R_HI;
      end
      R_HI: begin
        mdr_load_high = 1'b1;
        nxt = R_CAP;
      end
      R_CAP: begin
        nxt = IDLE; done_nxt = 1'b1;
      end
      W_ALO: begin
        bus_out = lat.addr; bus_oe = 1'b1; mar_load = 1'b1;
        nxt = W_DLO;
      end
      W_DLO: begin
        bus_out = {8'h00, lat.wdata[7:0]}; bus_oe = 1'b1; mdr_load_bus = 1'b1;
        nxt = W_WLO;
      end
      W_WLO: begin
        ram_write = 1'b1;
        if (lat.word) nxt = W_AHI;
        else begin nxt = IDLE; done_nxt = 1'b1; end
      end
      W_AHI: begin
        bus_out = lat.hi_addr; bus_oe = 1'b1; mar_load = 1'b1;
        nxt = W_DHI;
      end
      W_DHI: begin
        bus_out = {8'h00, lat.wdata[15:8]}; bus_oe = 1'b1; mdr_load_bus = 1'b1;
        nxt = W_WHI;
      end
      W_WHI: begin
        ram_write = 1'b1;
        nxt = IDLE; done_nxt = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural MAR/MDR/RAM model, per-cycle strobe
// expectations and a done/rdata/latency scoreboard.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, word;
  logic [15:0] addr, wdata, mem_data;
  logic [15:0] bus_out, rdata;
  logic        bus_oe, mar_load, mdr_load_bus, mdr_load_low, mdr_load_high, ram_write;
  logic        busy, done;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .word(word), .addr(addr),
    .wdata(wdata), .mem_data(mem_data), .bus_out(bus_out), .bus_oe(bus_oe),
    .mar_load(mar_load), .mdr_load_bus(mdr_load_bus), .mdr_load_low(mdr_load_low),
    .mdr_load_high(mdr_load_high), .ram_write(ram_write), .rdata(rdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // memory block model
  logic [7:0]  ram [0:65535];
  logic [15:0] mar, mdr, bus;
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  assign bus      = bus_oe ? bus_out : 16'h0000;
  assign mem_data = mdr;

  always @(posedge clk) begin
    if (pl_en)         ram[pl_addr] <= pl_data;
    if (mar_load)      mar <= bus;
    if (mdr_load_bus)  mdr <= bus;
    if (mdr_load_low)  mdr[7:0] <= ram[mar];
    if (mdr_load_high) mdr[15:8] <= ram[mar];
    if (ram_write)     ram[mar] <= mdr[7:0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // stb = {mar_load, mdr_load_bus, mdr_load_low, mdr_load_high, ram_write}
  typedef struct {
    logic        busy;
    logic        oe;
    logic [4:0]  stb;
    logic [15:0] bout;
  } cyc_t;

  typedef struct {
    int          acc;
    int          lat;
    logic [15:0] rd;
  } sb_t;

  cyc_t cq[$];
  sb_t  sq[$];
  logic [15:0] last_rd = 16'h0000;

  always @(negedge clk) begin
    cyc_t e;
    sb_t  s;
    if (!rst) begin
      if (cq.size() > 0) e = cq.pop_front();
      else e = '{busy: 1'b0, oe: 1'b0, stb: 5'b0, bout: 16'h0};
      chk("busy", {15'b0, busy}, {15'b0, e.busy});
      chk("bus_oe", {15'b0, bus_oe}, {15'b0, e.oe});
      chk("bus_out", bus_out, e.bout);
      chk("strobes", {11'b0, mar_load, mdr_load_bus, mdr_load_low, mdr_load_high, ram_write},
          {11'b0, e.stb});
      if (done) begin
        if (sq.size() == 0) chk("spurious_done", {15'b0, done}, 16'h0);
        else begin
          s = sq.pop_front();
          chk("latency", 16'(cyc - s.acc), 16'(s.lat));
          chk("rdata", rdata, s.rd);
        end
      end
    end
  end

  function automatic cyc_t c(input logic oe, input logic [4:0] stb, input logic [15:0] bo);
    c = '{busy: 1'b1, oe: oe, stb: stb, bout: bo};
  endfunction

  // call at negedge+1 while the DUT is (or is about to be) idle
  task automatic issue(input logic w, input logic wd, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd);
    int n0;
    logic [15:0] ah;
    ah = a + 16'd1;
    n0 = cq.size();
    req = 1'b1; we = w; word = wd; addr = a; wdata = d;
    if (!w) begin
      cq.push_back(c(1'b1, 5'b10000, a));
      cq.push_back(c(1'b0, 5'b00100, 16'h0));
      if (wd) begin
        cq.push_back(c(1'b1, 5'b10000, ah));
        cq.push_back(c(1'b0, 5'b00010, 16'h0));
      end
      cq.push_back(c(1'b0, 5'b00000, 16'h0));
      last_rd = exp_rd;
    end else begin
      cq.push_back(c(1'b1, 5'b10000, a));
      cq.push_back(c(1'b1, 5'b01000, {8'h00, d[7:0]}));
      cq.push_back(c(1'b0, 5'b00001, 16'h0));
      if (wd) begin
        cq.push_back(c(1'b1, 5'b10000, ah));
        cq.push_back(c(1'b1, 5'b01000, {8'h00, d[15:8]}));
        cq.push_back(c(1'b0, 5'b00001, 16'h0));
      end
    end
    sq.push_back('{acc: cyc + 1, lat: cq.size() - n0, rd: last_rd});
    @(negedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (done) return;
    end
    chk("done_timeout", {15'b0, done}, 16'h1);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; word = 1'b0; addr = '0; wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    preload(16'h0010, 8'h34);
    preload(16'h0011, 8'h12);
    preload(16'h0201, 8'h77);
    preload(16'h0300, 8'h11);
    preload(16'h0301, 8'h99);
    @(negedge clk); #1;
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_done", {15'b0, done}, 16'h0);
    chk("rst_busy", {15'b0, busy}, 16'h0);
    chk("rst_bus", {bus_oe, bus_out[14:0]} | {15'b0, bus_out[15]}, 16'h0);
    rst = 1'b0;
    @(negedge clk); #1;

    // word read with preloaded little-endian data
    issue(1'b0, 1'b1, 16'h0010, 16'h0, 16'h1234);
    wait_done();
    @(negedge clk); #1;

    // byte write then byte read back; upper wdata byte must not leak
    issue(1'b1, 1'b0, 16'h0200, 16'hCDAB, 16'h0);
    wait_done();
    issue(1'b0, 1'b0, 16'h0200, 16'h0, 16'h00AB);
    wait_done();
    chk("ram_0201", {8'h0, ram[16'h0201]}, 16'h0077);
    @(negedge clk); #1;

    // word write across the top of the address space
    issue(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0);
    wait_done();
    chk("ram_ffff", {8'h0, ram[16'hFFFF]}, 16'h00EF);
    chk("ram_0000", {8'h0, ram[16'h0000]}, 16'h00BE);
    @(negedge clk); #1;
    issue(1'b0, 1'b1, 16'hFFFF, 16'h0, 16'hBEEF);
    wait_done();
    @(negedge clk); #1;

    // req while busy is dropped; req in the done cycle is taken
    issue(1'b0, 1'b1, 16'h0010, 16'h0, 16'h1234);
    @(negedge clk); #1;
    req = 1'b1; we = 1'b1; word = 1'b0; addr = 16'h0200; wdata = 16'h5A5A;
    @(negedge clk); #1;
    req = 1'b0;
    wait_done();
    issue(1'b0, 1'b0, 16'h0011, 16'h0, 16'h0012);
    wait_done();
    chk("ram_0200_kept", {8'h0, ram[16'h0200]}, 16'h00AB);
    @(negedge clk); #1;

    // reset during W_DHI of a word write
    issue(1'b1, 1'b1, 16'h0300, 16'h5566, 16'h0);
    repeat (4) begin @(negedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort_busy", {15'b0, busy}, 16'h0);
    chk("abort_oe", {15'b0, bus_oe}, 16'h0);
    chk("abort_bus_out", bus_out, 16'h0);
    chk("abort_strobes", {11'b0, mar_load, mdr_load_bus, mdr_load_low, mdr_load_high, ram_write},
        16'h0);
    chk("abort_rdata", rdata, 16'h0);
    chk("abort_done", {15'b0, done}, 16'h0);
    cq.delete();
    sq.delete();
    last_rd = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("ram_0300", {8'h0, ram[16'h0300]}, 16'h0066);
    chk("ram_0301", {8'h0, ram[16'h0301]}, 16'h0099);
    chk("sb_drained", 16'(sq.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
